// File: rtl/req_arbiter8_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared definitions for the req_arbiter8 bus arbiter.
//   - N_REQ / ID_W : requester count and encoded id width
//   - arb_state_t  : arbiter FSM states
//   - rotl8/rotr8  : circular rotations of an 8-bit vector, used to rotate the
//                    request vector in round-robin mode
//   No ports (package).
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Result bit j takes v[(j - s) mod 8].
    function automatic logic [N_REQ-1:0] rotl8(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  s);
        logic [2*N_REQ-1:0] w;
        w = {v, v} << s;
        return w[2*N_REQ-1:N_REQ];
    endfunction

    // Result bit j takes v[(j + s) mod 8].
    function automatic logic [N_REQ-1:0] rotr8(input logic [N_REQ-1:0] v,
                                               input logic [ID_W-1:0]  s);
        logic [2*N_REQ-1:0] w;
        w = {v, v} >> s;
        return w[N_REQ-1:0];
    endfunction

endpackage

// File: rtl/req_arbiter8_prio_enc8.sv
// -----------------------------------------------------------------------------
// prio_enc8
//   Combinational 8:3 priority encoder. The highest set index wins.
//   Ports:
//     d   in  8  input vector
//     id  out 3  index of the highest set bit (0 when d is all zeros)
//     any out 1  OR of d
// -----------------------------------------------------------------------------
module prio_enc8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] d,
    output logic [ID_W-1:0]  id,
    output logic             any
);

    always_comb begin
        id = '0;
        // Ascending scan: the last (highest) set bit overwrites earlier ones.
        for (int i = 0; i < N_REQ; i++) begin
            if (d[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign any = |d;

endmodule

// File: rtl/req_arbiter8.sv
// -----------------------------------------------------------------------------
// req_arbiter8
//   Eight-requester bus arbiter. A registered one-hot grant is held until the
//   owner drops its request or MAX_HOLD cycles elapse. A one-cycle GAP always
//   separates consecutive owners, and requests are only sampled in IDLE.
//
//   Parameter:
//     MAX_HOLD  maximum grant length in cycles (legal 2..255)
//
//   Ports:
//     clk        in  1  clock, rising edge
//     rst        in  1  synchronous active-high reset
//     req        in  8  request vector
//     gnt        out 8  registered one-hot grant (zero when no owner)
//     gnt_id     out 3  encoded owner index, holds last value when idle
//     gnt_valid  out 1  grant active (OR of gnt)
//     timeout    out 1  one-cycle pulse during the GAP after a forced release
//
//   Build option:
//     ARB_ROUND_ROBIN_EN  rotating priority; the granted index becomes the
//                         lowest priority for the next decision. Undefined
//                         gives fixed priority with req[7] highest.
// -----------------------------------------------------------------------------
module req_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);

    arb_state_t       r_state,     w_state_nxt;
    logic [N_REQ-1:0] r_gnt,       w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id,    w_gnt_id_nxt;
    logic             r_gnt_valid, w_gnt_valid_nxt;
    logic             r_timeout,   w_timeout_nxt;
    logic [7:0]       r_hold_cnt,  w_hold_cnt_nxt;

    logic [N_REQ-1:0] w_enc_in;
    logic [ID_W-1:0]  w_enc_id;
    logic             w_enc_any;
    logic [ID_W-1:0]  w_win_id;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]  r_ptr, w_ptr_nxt;

    // Rotate so that index r_ptr lands on bit 7 (top priority of the encoder),
    // then undo the rotation on the encoded result with modulo-8 addition.
    assign w_enc_in = rotr8(req, r_ptr + 3'd1);
    assign w_win_id = w_enc_id + r_ptr + 3'd1;
`else
    assign w_enc_in = req;
    assign w_win_id = w_enc_id;
`endif

    prio_enc8 u_prio_enc8 (
        .d   (w_enc_in),
        .id  (w_enc_id),
        .any (w_enc_any)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        w_hold_cnt_nxt  = r_hold_cnt;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt       = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (w_enc_any) begin
                    w_state_nxt     = GRANT;
                    w_gnt_nxt       = N_REQ'(1) << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
`ifdef ARB_ROUND_ROBIN_EN
                    w_ptr_nxt       = w_win_id - 3'd1;
`endif
                end
            end
            GRANT: begin
                if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
                // Normal release has precedence, so timeout stays low when the
                // owner drops on the very cycle the limit is reached.
                if (!req[r_gnt_id]) begin
                    w_state_nxt     = GAP;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt     = GAP;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_timeout_nxt   = 1'b1;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr       <= 3'd7;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr       <= w_ptr_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_req_arbiter8.sv
// -----------------------------------------------------------------------------
// tb_req_arbiter8
//   Scoreboard bench for req_arbiter8. The stimulus process drives req/rst on
//   the falling edge and pushes the outputs expected after the next rising edge,
//   computed by a behavioural model (owner index, cycles held, gap flag and a
//   priority start index searched downward). A monitor pops one entry per
//   rising edge and compares all four outputs.
// -----------------------------------------------------------------------------
module tb_req_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    always #5 clk = ~clk;

    req_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int         m_owner = -1;  // index of current owner, -1 when none
    int         m_cnt   = 0;   // cycles the current owner has held the grant
    int         m_ptr   = 7;   // index with highest priority
    bit         m_gap   = 1'b0;
    logic [2:0] m_id    = 3'd0;
    logic       m_to    = 1'b0;

    // Search downward (with wrap) from the highest-priority index.
    function automatic int pick(input logic [7:0] r, input int ptr);
        int w;
        w = -1;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (ptr - k + 8) % 8;
            if (r[i] && w < 0) w = i;
        end
        return w;
    endfunction

    task automatic model_step(input logic [7:0] r, input logic rs);
        exp_t e;
        int   w;
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1; m_cnt = 0; m_gap = 1'b0; m_id = 3'd0; m_ptr = 7;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_id    = 3'(w);
                m_cnt   = 1;
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr   = (w + 7) % 8;
`endif
            end
        end else if (!r[m_owner]) begin
            m_owner = -1; m_gap = 1'b1;
        end else if (m_cnt == MAX_HOLD) begin
            m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
        end else begin
            m_cnt++;
        end
        e.gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.id  = m_id;
        e.vld = (m_owner >= 0);
        e.to  = m_to;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [7:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        model_step(r, rs);
    endtask

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    // Monitor: one expected entry per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                cmp("gnt",       gnt,              e.gnt);
                cmp("gnt_id",    {5'd0, gnt_id},   {5'd0, e.id});
                cmp("gnt_valid", {7'd0, gnt_valid}, {7'd0, e.vld});
                cmp("timeout",   {7'd0, timeout},  {7'd0, e.to});
            end
        end
    end

    initial begin
        // Reset, then idle
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        repeat (5) step(8'h00, 1'b0);

        // Two requesters, higher one first, then the lower one after a gap
        repeat (3) step(8'b0010_0010, 1'b0);
        repeat (5) step(8'b0000_0010, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // Long hold forcing a timeout (and a regrant in fixed mode)
        repeat (30) step(8'h80, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // All request; each owner drops one cycle after being granted
        for (int c = 0; c < 40; c++) begin
            logic [7:0] r;
            r = 8'hFF;
            if (m_owner >= 0 && m_cnt == 2) r[m_owner] = 1'b0;
            step(r, 1'b0);
        end
        repeat (3) step(8'h00, 1'b0);

        // No preemption of a low-index owner
        repeat (2) step(8'h01, 1'b0);
        repeat (4) step(8'h81, 1'b0);
        repeat (4) step(8'h80, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // Reset mid-grant
        repeat (4) step(8'h10, 1'b0);
        step(8'h10, 1'b1);
        repeat (4) step(8'h10, 1'b0);
        repeat (3) step(8'h00, 1'b0);

        // Randomized traffic, owner usually keeps requesting
        for (int c = 0; c < 600; c++) begin
            logic [7:0] r;
            logic       rs;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            if (m_owner >= 0 && $urandom_range(0, 9) < 9) r[m_owner] = 1'b1;
            rs = ($urandom_range(0, 99) == 0);
            step(r, rs);
        end

        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
